// File: rtl/swapper_pkg.sv
// -----------------------------------------------------------------------------
// swapper_pkg
// Shared encodings for the memory swapper datapath and its controller.
//   SEL_*  : swap step encoding carried on the controller's `sel` output.
//   ck_state_e : protocol checker state encoding (used when the design is
//                built with SWAPPER_SEQ_CHECK_EN defined).
// -----------------------------------------------------------------------------
package swapper_pkg;

    localparam logic [1:0] SEL_IDLE    = 2'd0;
    localparam logic [1:0] SEL_SAVE    = 2'd1;
    localparam logic [1:0] SEL_MOVE    = 2'd2;
    localparam logic [1:0] SEL_RESTORE = 2'd3;

    typedef enum logic [1:0] {
        CK_IDLE = 2'd0,
        CK_S1   = 2'd1,
        CK_S2   = 2'd2
    } ck_state_e;

endpackage

// File: rtl/swap_seq_checker.sv
// -----------------------------------------------------------------------------
// swap_seq_checker
// Watches the controller's w/sel stream and expects each swap to be exactly
// save -> move -> restore on consecutive w=1 cycles. Any other pattern is a
// violation: err is set (sticky) and the checker returns to CK_IDLE. A legal
// restore produces a one-cycle done pulse. The checker never gates data.
// Only compiled when SWAPPER_SEQ_CHECK_EN is defined, so the default build
// carries no checker logic at all.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   w, sel      : swap-step enable and step from the controller
//   load_acc    : host load accepted this cycle (clears err)
//   err         : sticky protocol-violation flag (registered)
//   done        : one-cycle pulse after a legal restore (registered)
// -----------------------------------------------------------------------------
`ifdef SWAPPER_SEQ_CHECK_EN
module swap_seq_checker (
    input  logic       clk,
    input  logic       reset,
    input  logic       w,
    input  logic [1:0] sel,
    input  logic       load_acc,
    output logic       err,
    output logic       done
);
    import swapper_pkg::*;

    ck_state_e state_q, state_d;
    logic      err_q, err_d;
    logic      done_q, done_d;
    logic      violation;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        violation = 1'b0;
        case (state_q)
            CK_IDLE: begin
                if (w) begin
                    if (sel == SEL_SAVE) state_d = CK_S1;
                    else                 violation = 1'b1;
                end
            end
            CK_S1: begin
                if (w && sel == SEL_MOVE) state_d = CK_S2;
                else                      violation = 1'b1;
            end
            CK_S2: begin
                if (w && sel == SEL_RESTORE) begin
                    state_d = CK_IDLE;
                    done_d  = 1'b1;
                end else begin
                    violation = 1'b1;
                end
            end
            default: state_d = CK_IDLE;
        endcase
        if (violation) state_d = CK_IDLE;
        // A violation in the same cycle as an accepted load keeps err set.
        if (violation)     err_d = 1'b1;
        else if (load_acc) err_d = 1'b0;
        else               err_d = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CK_IDLE;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign err  = err_q;
    assign done = done_q;

endmodule
`endif

// File: rtl/swapper_datapath.sv
// -----------------------------------------------------------------------------
// swapper_datapath
// Data-side responder for the memory swapper controller. Holds words A and B
// and a temp register T, and performs the swap step selected by w/sel:
// save (T<-A), move (A<-B), restore (B<-T). The host loads A/B with `load`
// while w=0; w=1 always takes priority and a coincident load is dropped.
// Optional macro SWAPPER_SEQ_CHECK_EN adds a protocol checker (err live,
// done only on legal completions). Without it err is 0 and done follows any
// restore step.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   load            : host load strobe for A/B
//   din_a, din_b    : load values
//   w, sel          : swap-step enable and step from the controller
//   dout_a, dout_b  : current A/B register contents
//   done            : one-cycle completion pulse
//   err             : sticky protocol-violation flag
// -----------------------------------------------------------------------------
module swapper_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic             w,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic             done,
    output logic             err
);
    import swapper_pkg::*;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic             load_acc;

    // A load only takes effect when the controller is not driving a step.
    assign load_acc = load & ~w;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        t_d = t_q;
        if (w) begin
            case (sel)
                SEL_SAVE:    t_d = a_q;
                SEL_MOVE:    a_d = b_q;
                SEL_RESTORE: b_d = t_q;
                default:     ;
            endcase
        end else if (load) begin
            a_d = din_a;
            b_d = din_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            t_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            t_q <= t_d;
        end
    end

    assign dout_a = a_q;
    assign dout_b = b_q;

`ifdef SWAPPER_SEQ_CHECK_EN
    swap_seq_checker u_checker (
        .clk      (clk),
        .reset    (reset),
        .w        (w),
        .sel      (sel),
        .load_acc (load_acc),
        .err      (err),
        .done     (done)
    );
`else
    logic done_q, done_d;

    // No sequence tracking: any restore step counts as a completion.
    assign done_d = w && (sel == SEL_RESTORE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= done_d;
    end

    assign done = done_q;
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_swapper_datapath.sv
// -----------------------------------------------------------------------------
// tb_swapper_datapath
// Directed bench for swapper_datapath. Expected values are hand-computed.
// Expectations that depend on the checker build key off SWAPPER_SEQ_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_swapper_datapath;

`ifdef SWAPPER_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] din_a;
    logic [7:0] din_b;
    logic       w;
    logic [1:0] sel;
    logic [7:0] dout_a;
    logic [7:0] dout_b;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    swapper_datapath #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .din_a  (din_a),
        .din_b  (din_b),
        .w      (w),
        .sel    (sel),
        .dout_a (dout_a),
        .dout_b (dout_b),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full check of the visible state after a step.
    task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic ed, input logic ee);
        chk({tag, ".a"}, dout_a, ea);
        chk({tag, ".b"}, dout_b, eb);
        chk({tag, ".done"}, {7'd0, done}, {7'd0, ed});
        chk({tag, ".err"}, {7'd0, err}, {7'd0, ee});
        $display("step %-14s a=%h b=%h done=%0b err=%0b", tag, dout_a, dout_b, done, err);
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cycle(input logic ld, input logic [7:0] da, input logic [7:0] db,
                         input logic ww, input logic [1:0] ss);
        @(negedge clk);
        load  = ld;
        din_a = da;
        din_b = db;
        w     = ww;
        sel   = ss;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0; din_a = '0; din_b = '0; w = 1'b0; sel = 2'd0;

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            load  = 1'($urandom);
            din_a = 8'($urandom);
            din_b = 8'($urandom);
            w     = 1'($urandom);
            sel   = 2'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        load = 1'b0; w = 1'b0; sel = 2'd0;
        #1;
        chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0);

        // Legal swap.
        cycle(1'b1, 8'h3C, 8'hA5, 1'b0, 2'd0); chk_all("load1",    8'h3C, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd1); chk_all("save1",    8'h3C, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd2); chk_all("move1",    8'hA5, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd3); chk_all("restore1", 8'hA5, 8'h3C, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 2'd0); chk_all("idle1",    8'hA5, 8'h3C, 1'b0, 1'b0);

        // Back-to-back swaps.
        cycle(1'b1, 8'h01, 8'h02, 1'b0, 2'd0); chk_all("load2",  8'h01, 8'h02, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd1); chk_all("b2b_s1", 8'h01, 8'h02, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd2); chk_all("b2b_m1", 8'h02, 8'h02, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd3); chk_all("b2b_r1", 8'h02, 8'h01, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd1); chk_all("b2b_s2", 8'h02, 8'h01, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd2); chk_all("b2b_m2", 8'h01, 8'h01, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd3); chk_all("b2b_r2", 8'h01, 8'h02, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 2'd0); chk_all("idle2",  8'h01, 8'h02, 1'b0, 1'b0);

        // Load ignored while a step is driven.
        cycle(1'b1, 8'h11, 8'h22, 1'b0, 2'd0); chk_all("load3",   8'h11, 8'h22, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd1); chk_all("ld_s",    8'h11, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 8'hEE, 1'b1, 2'd2); chk_all("ld_move", 8'h22, 8'h22, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd3); chk_all("ld_r",    8'h22, 8'h11, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 2'd0); chk_all("idle3",   8'h22, 8'h11, 1'b0, 1'b0);

        // Move from idle: violation in checker builds, data still moves.
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd2); chk_all("vio_move", 8'h11, 8'h11, 1'b0, CHK);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 2'd0); chk_all("vio_hold", 8'h11, 8'h11, 1'b0, CHK);
        cycle(1'b1, 8'h5A, 8'hC3, 1'b0, 2'd0); chk_all("vio_clr",  8'h5A, 8'hC3, 1'b0, 1'b0);
        // w drops after save together with a load: violation wins over clear.
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd1); chk_all("drop_s",   8'h5A, 8'hC3, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 8'h88, 1'b0, 2'd0); chk_all("drop_ld",  8'h77, 8'h88, 1'b0, CHK);
        cycle(1'b1, 8'h10, 8'h20, 1'b0, 2'd0); chk_all("clr2",     8'h10, 8'h20, 1'b0, 1'b0);
        // Lone restore from idle (T still holds 5A).
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd3); chk_all("lone_r",   8'h10, 8'h5A, !CHK, CHK);

        // Reset in the middle of a swap.
        cycle(1'b1, 8'h10, 8'h20, 1'b0, 2'd0); chk_all("load4",  8'h10, 8'h20, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd1); chk_all("mid_s",  8'h10, 8'h20, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd2); chk_all("mid_m",  8'h20, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        w = 1'b0; sel = 2'd0;
        #1;
        chk_all("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 8'h3C, 8'hA5, 1'b0, 2'd0); chk_all("load5", 8'h3C, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd1); chk_all("post_s", 8'h3C, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd2); chk_all("post_m", 8'hA5, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 2'd3); chk_all("post_r", 8'hA5, 8'h3C, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 2'd0); chk_all("idle5",  8'hA5, 8'h3C, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
